// File: rtl/riscv_fetch_unit.sv
// Instruction fetch unit: credit-limited request issue, in-order response queue and redirect flush.
// Define RISCV_FETCH_PERF_EN to build the delivered/redirect performance counters.
module riscv_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_redirects
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW:0] DepthLim = (CntW + 1)'(DEPTH);

  typedef enum logic [0:0] {StFetch, StFlush} state_e;

  state_e            state_q;
  logic [XLEN-1:0]   fetch_pc_q;
  logic [CntW-1:0]   outstanding_q, outstanding_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   head_q, tail_q;
  logic [31:0]       data_mem [DEPTH];
  logic [XLEN-1:0]   pc_mem   [DEPTH];

  logic              req_hs, rsp_acc, push, pop;
  logic [CntW:0]     occ_sum;
  logic [XLEN-1:0]   rsp_pc, redirect_target;
  logic              unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign redirect_target     = {redirect_pc[XLEN-1:2], 2'b00};

  assign occ_sum        = {1'b0, count_q} + {1'b0, outstanding_q};
  assign imem_req_valid = (state_q == StFetch) && (occ_sum < DepthLim);
  assign imem_req_addr  = fetch_pc_q;

  assign req_hs  = imem_req_valid && imem_req_ready;
  assign rsp_acc = imem_rsp_valid && (outstanding_q != '0);
  assign push    = rsp_acc && (state_q == StFetch) && !redirect_valid;
  assign pop     = inst_valid && inst_ready;

  // In FETCH every in-flight request is contiguous and ends just below fetch_pc, so the
  // oldest one's address is recovered arithmetically instead of storing it.
  assign rsp_pc = fetch_pc_q - (XLEN'(outstanding_q) << 2);

  assign inst_valid = (count_q != '0);
  assign inst_data  = data_mem[head_q];
  assign inst_pc    = pc_mem[head_q];

  always_comb begin
    outstanding_d = outstanding_q;
    case ({req_hs, rsp_acc})
      2'b10:   outstanding_d = outstanding_q + CntW'(1);
      2'b01:   outstanding_d = outstanding_q - CntW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StFetch;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      if (redirect_valid) begin
        // Requests accepted this cycle stay outstanding and are drained in FLUSH.
        fetch_pc_q <= redirect_target;
        count_q    <= '0;
        head_q     <= '0;
        tail_q     <= '0;
        state_q    <= (outstanding_d != '0) ? StFlush : StFetch;
      end else begin
        if (req_hs) fetch_pc_q <= fetch_pc_q + XLEN'(4);
        if (push)   tail_q     <= tail_q + PtrW'(1);
        if (pop)    head_q     <= head_q + PtrW'(1);
        count_q <= count_d;
        if ((state_q == StFlush) && (outstanding_d == '0)) state_q <= StFetch;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[tail_q] <= imem_rsp_data;
      pc_mem[tail_q]   <= rsp_pc;
    end
  end

`ifdef RISCV_FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_redirects_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched_q   <= '0;
      perf_redirects_q <= '0;
    end else begin
      if (pop)            perf_fetched_q   <= perf_fetched_q + 32'd1;
      if (redirect_valid) perf_redirects_q <= perf_redirects_q + 32'd1;
    end
  end

  assign perf_fetched   = perf_fetched_q;
  assign perf_redirects = perf_redirects_q;
`else
  assign perf_fetched   = '0;
  assign perf_redirects = '0;
`endif

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Self-checking bench for riscv_fetch_unit: directed scenarios plus a randomized run against
// an epoch-based transaction model of fetch, flush and delivery.
module tb_riscv_fetch_unit;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;
  logic [31:0] perf_fetched, perf_redirects;

  int checks = 0;
  int errors = 0;

  riscv_fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .perf_fetched   (perf_fetched),
    .perf_redirects (perf_redirects)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory contents: a bijection of the address so stale or misplaced words are visible.
  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] exp_perf(input int unsigned n);
`ifdef RISCV_FETCH_PERF_EN
    return n;
`else
    return 32'd0 & n;
`endif
  endfunction

  logic        last_hs;
  logic [31:0] last_addr;
  logic [31:0] hs_addrs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
    redirect_valid = 0; redirect_pc = '0; inst_ready = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    tick(); tick();
    rst_n = 1;
    last_hs = 0; last_addr = '0;
    hs_addrs.delete();
  endtask

  task automatic redirect_idle(input logic [31:0] pc);
    redirect_valid = 1; redirect_pc = pc; imem_req_ready = 0;
    tick();
    redirect_valid = 0;
  endtask

  // One cycle of a latency-1 memory.
  task automatic mem_cycle(input logic rdy);
    imem_req_ready = rdy;
    imem_rsp_valid = last_hs;
    imem_rsp_data  = word(last_addr);
    last_hs   = imem_req_valid && rdy;
    last_addr = imem_req_addr;
    if (last_hs) hs_addrs.push_back(last_addr);
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] exp_addr [4];
    exp_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    rst_n = 0;
    for (int i = 0; i < 3; i++) begin
      imem_req_ready = 1'($urandom); imem_rsp_valid = 1'($urandom);
      redirect_valid = 1'($urandom); redirect_pc = $urandom; inst_ready = 1'($urandom);
      tick();
    end
    clear_inputs();
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid);
    end
    checks++;
    if (imem_req_addr !== RST_PC) begin
      errors++; $display("FAIL reset_pc: got %h want %h", imem_req_addr, RST_PC);
    end
    checks++;
    if (perf_fetched !== 32'd0 || perf_redirects !== 32'd0) begin
      errors++; $display("FAIL reset_perf: got %h/%h want 0/0", perf_fetched, perf_redirects);
    end
    rst_n = 1;
    imem_req_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_addr[i]) begin
        errors++;
        $display("FAIL wrap_addr[%0d]: got v=%b %h want v=1 %h", i, imem_req_valid,
                 imem_req_addr, exp_addr[i]);
      end
      tick();
    end
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL credit_stop: got req_valid=%b want 0", imem_req_valid);
    end
    imem_req_ready = 0;
  endtask

  task automatic test_fill();
    do_reset();
    redirect_idle(32'h0);
    inst_ready = 0;
    for (int i = 0; i < 10; i++) mem_cycle(1'b1);
    checks++;
    if (hs_addrs.size() != 4) begin
      errors++; $display("FAIL fill_count: got %0d requests want 4", hs_addrs.size());
    end
    for (int i = 0; i < hs_addrs.size() && i < 4; i++) begin
      checks++;
      if (hs_addrs[i] !== 32'(4 * i)) begin
        errors++; $display("FAIL fill_addr[%0d]: got %h want %h", i, hs_addrs[i], 32'(4 * i));
      end
    end
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL fill_stop: got req_valid=%b want 0", imem_req_valid);
    end
    inst_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * i) || inst_data !== word(32'(4 * i))) begin
        errors++;
        $display("FAIL fill_head[%0d]: got v=%b pc=%h d=%h want v=1 pc=%h d=%h", i, inst_valid,
                 inst_pc, inst_data, 32'(4 * i), word(32'(4 * i)));
      end
      mem_cycle(1'b0);
    end
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++; $display("FAIL fill_drained: got inst_valid=%b want 0", inst_valid);
    end
  endtask

  task automatic test_stream();
    do_reset();
    redirect_idle(32'h0);
    inst_ready = 1;
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * k)) begin
        errors++;
        $display("FAIL stream_req[%0d]: got v=%b %h want v=1 %h", k, imem_req_valid,
                 imem_req_addr, 32'(4 * k));
      end
      if (k >= 2) begin
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * (k - 2))) begin
          errors++;
          $display("FAIL stream_inst[%0d]: got v=%b pc=%h want v=1 pc=%h", k, inst_valid,
                   inst_pc, 32'(4 * (k - 2)));
        end
      end
      mem_cycle(1'b1);
    end
    checks++;
    if (perf_fetched !== exp_perf(10) || perf_redirects !== exp_perf(1)) begin
      errors++;
      $display("FAIL stream_perf: got %0d/%0d want %0d/%0d", perf_fetched, perf_redirects,
               exp_perf(10), exp_perf(1));
    end
    clear_inputs();
  endtask

  task automatic test_flush();
    bit found = 0;
    do_reset();
    redirect_idle(32'h0);
    imem_req_ready = 1;
    tick(); tick();
    imem_req_ready = 0; redirect_valid = 1; redirect_pc = 32'h103;
    tick();
    redirect_valid = 0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_quiet[%0d]: got req=%b inst=%b want 0/0", i, imem_req_valid,
                 inst_valid);
      end
      imem_rsp_valid = 1; imem_rsp_data = word(32'(4 * i));
      tick();
    end
    imem_rsp_valid = 0;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_exit: got req=%b addr=%h inst=%b want 1 100 0", imem_req_valid,
               imem_req_addr, inst_valid);
    end
    inst_ready = 1; last_hs = 0;
    for (int i = 0; i < 6; i++) begin
      if (inst_valid) begin
        found = 1;
        checks++;
        if (inst_pc !== 32'h100 || inst_data !== word(32'h100)) begin
          errors++;
          $display("FAIL flush_first: got pc=%h d=%h want pc=100 d=%h", inst_pc, inst_data,
                   word(32'h100));
        end
        break;
      end
      mem_cycle(1'b1);
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL flush_timeout: got no instruction want pc=100 within 6 cycles");
    end
    clear_inputs();
  endtask

  task automatic test_redirect_pop_rsp();
    do_reset();
    redirect_idle(32'h0);
    mem_cycle(1'b1);
    mem_cycle(1'b1);
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
      errors++; $display("FAIL rpr_head: got v=%b pc=%h want v=1 pc=0", inst_valid, inst_pc);
    end
    imem_req_ready = 0; inst_ready = 1;
    redirect_valid = 1; redirect_pc = 32'h200;
    imem_rsp_valid = 1; imem_rsp_data = word(32'h4);
    tick();
    clear_inputs();
    checks++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
      errors++;
      $display("FAIL rpr_state: got inst=%b req=%b addr=%h want 0 1 200", inst_valid,
               imem_req_valid, imem_req_addr);
    end
    checks++;
    if (perf_fetched !== exp_perf(1) || perf_redirects !== exp_perf(2)) begin
      errors++;
      $display("FAIL rpr_perf: got %0d/%0d want %0d/%0d", perf_fetched, perf_redirects,
               exp_perf(1), exp_perf(2));
    end
    tick();
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++; $display("FAIL rpr_dropped: got inst_valid=%b want 0", inst_valid);
    end
  endtask

  task automatic test_spurious();
    do_reset();
    imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = $urandom;
    tick(); tick(); tick();
    clear_inputs();
    checks++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
      errors++;
      $display("FAIL spurious: got inst=%b req=%b addr=%h want 0 1 %h", inst_valid,
               imem_req_valid, imem_req_addr, RST_PC);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  task automatic test_random();
    req_t        pending[$];
    logic [31:0] fifo[$];
    logic [31:0] exp_req_pc;
    int          epoch, n_fetched, n_redir, total_pops, old_cnt;
    bit          exp_req, hs, pop, rsp_real;
    do_reset();
    exp_req_pc = RST_PC; epoch = 0; n_fetched = 0; n_redir = 0; total_pops = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(499) == 0) begin
        rst_n = 0;
        imem_req_ready = 1'($urandom); imem_rsp_valid = 1'($urandom);
        redirect_valid = 1'($urandom); inst_ready = 1'($urandom);
        tick();
        rst_n = 1;
        pending.delete(); fifo.delete();
        exp_req_pc = RST_PC; n_fetched = 0; n_redir = 0;
        continue;
      end
      old_cnt = 0;
      foreach (pending[i]) if (pending[i].epoch != epoch) old_cnt++;
      exp_req = (old_cnt == 0) && (fifo.size() + pending.size() < DEPTH);
      checks++;
      if (imem_req_valid !== exp_req || (exp_req && imem_req_addr !== exp_req_pc)) begin
        errors++;
        $display("FAIL rnd_req@%0d: got v=%b %h want v=%b %h", cyc, imem_req_valid,
                 imem_req_addr, exp_req, exp_req_pc);
      end
      checks++;
      if (inst_valid !== (fifo.size() != 0) ||
          (fifo.size() != 0 && (inst_pc !== fifo[0] || inst_data !== word(fifo[0])))) begin
        errors++;
        $display("FAIL rnd_inst@%0d: got v=%b pc=%h d=%h want v=%b pc=%h", cyc, inst_valid,
                 inst_pc, inst_data, fifo.size() != 0, (fifo.size() != 0) ? fifo[0] : 32'h0);
      end
      checks++;
      if (perf_fetched !== exp_perf(n_fetched) || perf_redirects !== exp_perf(n_redir)) begin
        errors++;
        $display("FAIL rnd_perf@%0d: got %0d/%0d want %0d/%0d", cyc, perf_fetched,
                 perf_redirects, exp_perf(n_fetched), exp_perf(n_redir));
      end
      imem_req_ready = ($urandom_range(3) != 0);
      inst_ready     = ($urandom_range(2) != 0);
      redirect_valid = ($urandom_range(15) == 0);
      redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15))
                                                 : $urandom;
      rsp_real = (pending.size() != 0) && (pending[0].due <= cyc) && ($urandom_range(3) != 0);
      if (rsp_real) begin
        imem_rsp_valid = 1; imem_rsp_data = word(pending[0].addr);
      end else begin
        imem_rsp_valid = (pending.size() == 0) && ($urandom_range(7) == 0);
        imem_rsp_data  = $urandom;
      end
      hs  = exp_req && imem_req_ready;
      pop = (fifo.size() != 0) && inst_ready;
      if (pop) begin
        void'(fifo.pop_front()); n_fetched++; total_pops++;
      end
      if (rsp_real) begin
        req_t r = pending.pop_front();
        if (r.epoch == epoch && !redirect_valid) fifo.push_back(r.addr);
      end
      if (hs) begin
        pending.push_back('{addr: exp_req_pc, epoch: epoch, due: cyc + $urandom_range(3, 1)});
        exp_req_pc += 32'd4;
      end
      if (redirect_valid) begin
        fifo.delete(); epoch++; n_redir++;
        exp_req_pc = {redirect_pc[31:2], 2'b00};
      end
      tick();
    end
    clear_inputs();
    checks++;
    if (total_pops < 300) begin
      errors++; $display("FAIL rnd_progress: got %0d deliveries want >= 300", total_pops);
    end
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    last_hs = 0; last_addr = '0;
    test_reset();
    test_fill();
    test_stream();
    test_flush();
    test_redirect_pop_rsp();
    test_spurious();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_fetch_unit.md
RISCV_FETCH_UNIT -- requirements
Module: riscv_fetch_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning address/instruction width (32 or 64).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning instruction queue entries (power of two, 2..16).
REQ-003 The block SHALL have parameter RESET_PC, default 0, meaning fetch address after reset (word aligned).
REQ-004 The block SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 The block SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-007 The block SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-008 The block SHALL have port imem_req_addr  output  XLEN  fetch address.
REQ-009 The block SHALL have port imem_rsp_valid  input  1  in-order response valid, latency >= 1 cycle.
REQ-010 The block SHALL have port imem_rsp_data  input  32  fetched instruction.
REQ-011 The block SHALL have port redirect_valid  input  1  branch/jump redirect.
REQ-012 The block SHALL have port redirect_pc  input  XLEN  redirect target.
REQ-013 The block SHALL have port inst_valid  output  1  queue head valid.
REQ-014 The block SHALL have port inst_ready  input  1  decode consumes head.
REQ-015 The block SHALL have port inst_data  output  32  head instruction.
REQ-016 The block SHALL have port inst_pc  output  XLEN  head instruction address.
REQ-017 The block SHALL have port perf_fetched  output  32  instructions delivered count.
REQ-018 The block SHALL have port perf_redirects  output  32  redirect count.

Function
REQ-019 The block SHALL implement states FETCH and FLUSH. FETCH: issue requests. FLUSH: issue none, discard in-flight responses.
REQ-020 In FETCH, imem_req_valid SHALL equal (occupancy + outstanding < DEPTH), and imem_req_addr SHALL equal fetch_pc.
REQ-021 On req handshake, fetch_pc SHALL advance by 4, mod 2^XLEN; wrap from all-ones-minus-3 to 0 is legal.
REQ-022 On req handshake, outstanding SHALL increment. On accepted response, outstanding SHALL decrement. Simultaneous handshake and response SHALL leave it unchanged.
REQ-023 In FETCH, a response SHALL be written to the queue tail with its request address. The head SHALL be visible on inst_* the next cycle (response-to-inst_valid latency 1).
REQ-024 The head SHALL pop on inst_valid && inst_ready. Push and pop in the same cycle SHALL keep occupancy; when the queue is full, the credit rule guarantees no overflow.
REQ-025 On redirect_valid, the next edge SHALL:
  - flush the queue (inst_valid=0);
  - load fetch_pc with {redirect_pc[XLEN-1:2],2'b00};
  - enter FLUSH if outstanding (after this cycle's updates) > 0, else stay in FETCH.
REQ-026 A redirect SHALL win over a same-cycle request and push. A pop in the redirect cycle SHALL still count as delivered. A request whose handshake completes in the redirect cycle SHALL be counted outstanding and discarded later.
REQ-027 In FLUSH, responses SHALL be dropped. The block SHALL return to FETCH on the edge where outstanding reaches 0.
REQ-028 A redirect in FLUSH SHALL update fetch_pc and remain in FLUSH.
REQ-029 Responses arriving while outstanding==0 SHALL be ignored.

Reset
REQ-030 While rst_n=0 at an edge, the block SHALL set:
  - state=FETCH, fetch_pc=RESET_PC;
  - queue empty, outstanding=0;
  - counters=0, inst_valid=0.
REQ-031 The first request SHALL be presented in the first cycle after rst_n is sampled high. Reset mid-operation SHALL abandon all in-flight work.

Configuration
REQ-032 With macro RISCV_FETCH_PERF_EN defined, perf_fetched SHALL increment per pop and perf_redirects SHALL increment per redirect, both wrapping at 2^32.
REQ-033 Without RISCV_FETCH_PERF_EN, both perf ports SHALL be tied to 0 and no counter flops SHALL exist.

Verification
REQ-034 Reset release, memory latency 1, inst_ready=1 -> addresses 0,4,8,... issued each cycle; inst_pc follows, 2 cycles behind request.
REQ-035 DEPTH=4, inst_ready=0 -> exactly 4 requests issued, then imem_req_valid=0; the queue holds PCs 0,4,8,C.
REQ-036 Redirect to 0x103 with 2 requests outstanding -> FLUSH, next 2 responses dropped, then request at 0x100, first inst_pc=0x100.
REQ-037 RESET_PC=0xFFFFFFF8, XLEN=32 -> request addresses FFFFFFF8, FFFFFFFC, 00000000.
REQ-038 Redirect, pop and response in the same cycle -> queue empty next cycle; with RISCV_FETCH_PERF_EN, perf_fetched +1 and perf_redirects +1.
